// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multi-cycle main control FSM.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_ALUWB, S_MEMADDR,
        S_MEMREAD, S_MEMWB, S_MEMWRITE, S_BRANCH, S_JAL, S_TRAP
    } state_t;

    typedef enum logic [2:0] {
        CLS_R, CLS_I, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_JAL, CLS_ILL
    } op_class_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;

    localparam logic [1:0] M2R_ALUOUT = 2'b00;
    localparam logic [1:0] M2R_MDR    = 2'b01;
    localparam logic [1:0] M2R_PC     = 2'b10;

    // Datapath control word; field order matches the top-level output order.
    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       i_or_d;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] aluop;
        logic       reg_write;
        logic [1:0] mem_to_reg;
    } ctl_t;

endpackage

// File: rtl/ctrl_opcode_dec.sv
// Opcode -> instruction class used by DECODE/MEMADDR dispatch.
// Optional feature macro: JAL_EN (jal recognised; otherwise it decodes as illegal).
module ctrl_opcode_dec
    import ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output op_class_t  op_class
);

    // Pure lookup; anything unrecognised is illegal.
    always_comb begin
        op_class = CLS_ILL;
        case (opcode)
            OP_R:      op_class = CLS_R;
            OP_I:      op_class = CLS_I;
            OP_LOAD:   op_class = CLS_LOAD;
            OP_STORE:  op_class = CLS_STORE;
            OP_BRANCH: op_class = CLS_BRANCH;
`ifdef JAL_EN
            OP_JAL:    op_class = CLS_JAL;
`endif
            default:   op_class = CLS_ILL;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle main control FSM with memory handshake and retired-instruction counter.
// Optional feature macro: JAL_EN (adds the single-cycle JAL state).
module multicycle_control
    import ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             i_or_d,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic [1:0]       pc_source,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       aluop,
    output logic             reg_write,
    output logic [1:0]       mem_to_reg,
    output logic             illegal,
    output logic [CNT_W-1:0] instret
);

    state_t           state, state_nx;
    op_class_t        op_class;
    ctl_t             ctl;
    logic             retire;
    logic             illegal_q;
    logic [CNT_W-1:0] instret_q;

    ctrl_opcode_dec u_dec (
        .opcode   (opcode),
        .op_class (op_class)
    );

    // Outputs are forced low while reset is held so a request in flight drops immediately.
    assign {mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond,
            pc_source, alu_src_a, alu_src_b, aluop, reg_write, mem_to_reg} = rst_n ? ctl : '0;
    assign illegal = illegal_q;
    assign instret = instret_q;

    // State, sticky illegal flag and retire counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_FETCH;
            illegal_q <= 1'b0;
            instret_q <= '0;
        end else begin
            state <= state_nx;
            if (state_nx == S_TRAP) illegal_q <= 1'b1;
            if (retire) instret_q <= instret_q + CNT_W'(1);
        end
    end

    // Next state, retire strobe and Moore control word (FETCH writes gated by mem_ready).
    always_comb begin
        state_nx = state;
        retire   = 1'b0;
        ctl      = '0;
        case (state)
            S_FETCH: begin
                ctl.mem_req   = 1'b1;
                ctl.alu_src_a = SRCA_PC;
                ctl.alu_src_b = SRCB_FOUR;
                ctl.aluop     = ALUOP_ADD;
                ctl.pc_source = PCSRC_ALU;
                ctl.ir_write  = mem_ready;
                ctl.pc_write  = mem_ready;
                if (mem_ready) state_nx = S_DECODE;
            end
            S_DECODE: begin
                ctl.alu_src_a = SRCA_OLDPC;
                ctl.alu_src_b = SRCB_IMM;
                ctl.aluop     = ALUOP_ADD;
                case (op_class)
                    CLS_R:                state_nx = S_EXEC_R;
                    CLS_I:                state_nx = S_EXEC_I;
                    CLS_LOAD, CLS_STORE:  state_nx = S_MEMADDR;
                    CLS_BRANCH:           state_nx = S_BRANCH;
                    CLS_JAL:              state_nx = S_JAL;
                    default:              state_nx = S_TRAP;
                endcase
            end
            S_EXEC_R: begin
                ctl.alu_src_a = SRCA_RS1;
                ctl.alu_src_b = SRCB_RS2;
                ctl.aluop     = ALUOP_FUNCT;
                state_nx      = S_ALUWB;
            end
            S_EXEC_I: begin
                ctl.alu_src_a = SRCA_RS1;
                ctl.alu_src_b = SRCB_IMM;
                ctl.aluop     = ALUOP_ADD;
                state_nx      = S_ALUWB;
            end
            S_ALUWB: begin
                ctl.reg_write  = 1'b1;
                ctl.mem_to_reg = M2R_ALUOUT;
                state_nx       = S_FETCH;
                retire         = 1'b1;
            end
            S_MEMADDR: begin
                ctl.alu_src_a = SRCA_RS1;
                ctl.alu_src_b = SRCB_IMM;
                ctl.aluop     = ALUOP_ADD;
                state_nx      = (op_class == CLS_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                ctl.mem_req = 1'b1;
                ctl.i_or_d  = 1'b1;
                if (mem_ready) state_nx = S_MEMWB;
            end
            S_MEMWB: begin
                ctl.reg_write  = 1'b1;
                ctl.mem_to_reg = M2R_MDR;
                state_nx       = S_FETCH;
                retire         = 1'b1;
            end
            S_MEMWRITE: begin
                ctl.mem_req = 1'b1;
                ctl.i_or_d  = 1'b1;
                ctl.mem_we  = 1'b1;
                if (mem_ready) begin
                    state_nx = S_FETCH;
                    retire   = 1'b1;
                end
            end
            S_BRANCH: begin
                ctl.alu_src_a     = SRCA_RS1;
                ctl.alu_src_b     = SRCB_RS2;
                ctl.aluop         = ALUOP_SUB;
                ctl.pc_write_cond = 1'b1;
                ctl.pc_source     = PCSRC_ALUOUT;
                state_nx          = S_FETCH;
                retire            = 1'b1;
            end
`ifdef JAL_EN
            S_JAL: begin
                ctl.alu_src_a  = SRCA_OLDPC;
                ctl.alu_src_b  = SRCB_IMM;
                ctl.aluop      = ALUOP_ADD;
                ctl.pc_write   = 1'b1;
                ctl.pc_source  = PCSRC_ALU;
                ctl.reg_write  = 1'b1;
                ctl.mem_to_reg = M2R_PC;
                state_nx       = S_FETCH;
                retire         = 1'b1;
            end
`endif
            S_TRAP:  state_nx = S_TRAP;
            default: state_nx = S_FETCH;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control (CNT_W=4 so the counter wrap is reachable).
// Expected control words are queued as each cycle is driven and compared on the falling edge.
module tb_multicycle_control;

    localparam int CW = 4;

    localparam int T_FETCH = 0, T_DECODE = 1, T_EXEC_R = 2, T_EXEC_I = 3, T_ALUWB = 4,
                   T_MEMADDR = 5, T_MEMREAD = 6, T_MEMWB = 7, T_MEMWRITE = 8,
                   T_BRANCH = 9, T_JAL = 10, T_TRAP = 11;

    typedef struct packed {
        logic       mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond;
        logic [1:0] pc_source, alu_src_a, alu_src_b, aluop;
        logic       reg_write;
        logic [1:0] mem_to_reg;
        logic       illegal;
    } exp_t;

    typedef struct {
        logic [6:0] op;
        int         fw;
        int         mw;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [6:0]    opcode = 7'd0;
    logic          mem_ready = 1'b0;
    logic          mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond;
    logic [1:0]    pc_source, alu_src_a, alu_src_b, aluop, mem_to_reg;
    logic          reg_write, illegal;
    logic [CW-1:0] instret;

    int            checks = 0;
    int            failures = 0;
    logic [CW-1:0] exp_cnt = '0;
    exp_t          eq[$];
    int            sq[$];
    vec_t          tbl[7];

    multicycle_control #(.CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .i_or_d(i_or_d), .ir_write(ir_write),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .aluop(aluop),
        .reg_write(reg_write), .mem_to_reg(mem_to_reg), .illegal(illegal), .instret(instret)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "timeout");
    end

    function automatic exp_t act_word();
        return {mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond,
                pc_source, alu_src_a, alu_src_b, aluop, reg_write, mem_to_reg, illegal};
    endfunction

    // Control word the spec's state table requires for state st with the given mem_ready.
    function automatic exp_t expect_ctl(input int st, input logic rdy, input logic ill);
        exp_t e = '0;
        e.illegal = ill;
        case (st)
            T_FETCH:    begin e.mem_req = 1; e.alu_src_b = 2'b01; e.ir_write = rdy; e.pc_write = rdy; end
            T_DECODE:   begin e.alu_src_a = 2'b01; e.alu_src_b = 2'b10; end
            T_EXEC_R:   begin e.alu_src_a = 2'b10; e.aluop = 2'b10; end
            T_EXEC_I:   begin e.alu_src_a = 2'b10; e.alu_src_b = 2'b10; end
            T_ALUWB:    e.reg_write = 1;
            T_MEMADDR:  begin e.alu_src_a = 2'b10; e.alu_src_b = 2'b10; end
            T_MEMREAD:  begin e.mem_req = 1; e.i_or_d = 1; end
            T_MEMWB:    begin e.reg_write = 1; e.mem_to_reg = 2'b01; end
            T_MEMWRITE: begin e.mem_req = 1; e.i_or_d = 1; e.mem_we = 1; end
            T_BRANCH:   begin e.alu_src_a = 2'b10; e.aluop = 2'b01; e.pc_write_cond = 1; e.pc_source = 2'b01; end
            T_JAL:      begin e.alu_src_a = 2'b01; e.alu_src_b = 2'b10; e.pc_write = 1;
                              e.reg_write = 1; e.mem_to_reg = 2'b10; end
            default:    e.illegal = 1;
        endcase
        return e;
    endfunction

    // Scoreboard: compare the word queued for this cycle against the DUT.
    always @(negedge clk) begin
        if (eq.size() > 0) begin
            exp_t e;
            int   st;
            e  = eq.pop_front();
            st = sq.pop_front();
            checks++;
            if (act_word() !== e) begin
                failures++;
                $display("FAIL ctl_state%0d got=%h exp=%h t=%0t", st, act_word(), e, $time);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Drive one cycle (called #1 after a rising edge) and queue its expectation.
    task automatic step(input int st, input logic rdy, input logic ill = 1'b0);
        mem_ready = rdy;
        eq.push_back(expect_ctl(st, rdy, ill));
        sq.push_back(st);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string nm);
        rst_n = 1'b0;
        #2;
        chk({nm, "_ctl"}, 32'(act_word()), 32'd0);
        chk({nm, "_instret"}, 32'(instret), 32'd0);
        exp_cnt = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic run_instr(input logic [6:0] op, input int fw, input int mw);
        logic ret = 1'b0;
        opcode = op;
        for (int i = 0; i < fw; i++) step(T_FETCH, 1'b0);
        step(T_FETCH, 1'b1);
        step(T_DECODE, 1'b1);          // mem_ready outside a request must be ignored
        case (op)
            7'b0110011: begin step(T_EXEC_R, 1'b1); step(T_ALUWB, 1'b0); ret = 1; end
            7'b0010011: begin step(T_EXEC_I, 1'b1); step(T_ALUWB, 1'b1); ret = 1; end
            7'b0000011: begin
                step(T_MEMADDR, 1'b1);
                for (int i = 0; i < mw; i++) step(T_MEMREAD, 1'b0);
                step(T_MEMREAD, 1'b1);
                step(T_MEMWB, 1'b1);
                ret = 1;
            end
            7'b0100011: begin
                step(T_MEMADDR, 1'b1);
                for (int i = 0; i < mw; i++) step(T_MEMWRITE, 1'b0);
                step(T_MEMWRITE, 1'b1);
                ret = 1;
            end
            7'b1100011: begin step(T_BRANCH, 1'b1); ret = 1; end
`ifdef JAL_EN
            7'b1101111: begin step(T_JAL, 1'b1); ret = 1; end
`endif
            default: begin
                for (int i = 0; i < 3; i++) step(T_TRAP, 1'b1, 1'b1);
            end
        endcase
        if (ret) begin
            exp_cnt = exp_cnt + 1'b1;
            chk("instret", 32'(instret), 32'(exp_cnt));
        end
    endtask

    initial begin
        tbl[0] = '{7'b0110011, 0, 0};   // add
        tbl[1] = '{7'b0000011, 1, 3};   // lw, slow fetch, 3 wait cycles
        tbl[2] = '{7'b0100011, 0, 2};   // sw, 2 wait cycles
        tbl[3] = '{7'b1100011, 0, 0};   // beq
        tbl[4] = '{7'b0010011, 2, 0};   // addi, slow fetch
        tbl[5] = '{7'b0000011, 0, 0};   // lw, ready at once
        tbl[6] = '{7'b0100011, 0, 0};   // sw, ready at once

        #2;
        chk("reset_ctl", 32'(act_word()), 32'd0);
        chk("reset_instret", 32'(instret), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        foreach (tbl[i]) run_instr(tbl[i].op, tbl[i].fw, tbl[i].mw);

        // jal: retires with link writeback when enabled, traps otherwise
        run_instr(7'b1101111, 0, 0);
        do_reset("rst_after_jal");

        // unknown opcode traps; reset clears the sticky flag
        run_instr(7'b1111111, 0, 0);
        chk("trap_illegal", 32'(illegal), 32'd1);
        do_reset("rst_after_trap");

        // counter wrap at CNT_W=4: 16 retires from 0 lands back on 0
        for (int i = 0; i < 16; i++) run_instr(7'b0010011, 0, 0);
        chk("instret_wrap", 32'(instret), 32'd0);

        // asynchronous reset in the middle of a stalled load
        opcode = 7'b0000011;
        step(T_FETCH, 1'b1);
        step(T_DECODE, 1'b0);
        step(T_MEMADDR, 1'b0);
        step(T_MEMREAD, 1'b0);
        chk("memread_pending", 32'({mem_req, i_or_d}), 32'd3);
        do_reset("rst_mid_memread");

        // recovery after reset
        run_instr(7'b0110011, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
